// File: rtl/dpram_pkg.sv
// Shared dual-port RAM definitions: default widths and the read-initiator state encoding.
`default_nettype none

package dpram_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;
endpackage

`default_nettype wire

// File: rtl/dpram_rd_skid.sv
// Two-entry {last, data} FIFO absorbing RAM read returns, with a valid/ready output side.
`default_nettype none

module dpram_rd_skid
  import dpram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  output logic [1:0]        occ_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o
);

  logic [DATA_W:0] mem_q [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      count_q;
  logic            w_pop;

  assign w_pop = m_valid_o & m_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_i} - {1'b0, w_pop};
    end
  end

  // Head entry is held until popped, so outputs are stable under stall.
  assign occ_o                = count_q;
  assign m_valid_o            = (count_q != 2'd0);
  assign {m_last_o, m_data_o} = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/dpram_burst_reader.sv
// Burst read initiator for one RAM port: issues single-word reads under a 2-word credit
// limit and streams the returned words out with a last-beat marker.
`default_nettype none

module dpram_burst_reader
  import dpram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              rd_pend_q;
  logic              rd_last_q;
  logic              zdone_q;

  logic [1:0] w_occ;
  logic [2:0] w_used;
  logic       w_pop;
  logic       w_issue;
  logic       w_cmd_fire;
  logic       w_last_issue;

  assign w_cmd_fire   = cmd_valid & cmd_ready;
  assign w_pop        = m_valid & m_ready;
  assign w_used       = {1'b0, w_occ} + {2'b0, rd_pend_q};
  // A beat leaving this cycle frees its slot in time for a new read, giving 1 word/cycle.
  assign w_issue      = (state_q == ISSUE) && (w_used < (3'd2 + {2'b0, w_pop}));
  assign w_last_issue = w_issue && (remaining_q == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_cmd_fire && (cmd_len != '0)) state_d = ISSUE;
      ISSUE:   if (w_last_issue) state_d = DRAIN;
      DRAIN:   if (w_pop && m_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    ram_en    = w_issue;
    ram_we    = 1'b0;
    ram_addr  = cur_addr_q;
    done      = zdone_q | ((state_q == DRAIN) & w_pop & m_last);
  end

  always_comb begin
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    if (w_cmd_fire && (cmd_len != '0)) begin
      cur_addr_d  = cmd_addr;
      remaining_d = cmd_len;
    end else if (w_issue) begin
      cur_addr_d  = cur_addr_q + ADDR_W'(1);
      remaining_d = remaining_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
      zdone_q     <= 1'b0;
    end else begin
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rd_pend_q   <= w_issue;
      rd_last_q   <= w_last_issue;
      zdone_q     <= w_cmd_fire && (cmd_len == '0);
    end
  end

  dpram_rd_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (rd_pend_q),
    .push_data_i(ram_dout),
    .push_last_i(rd_last_q),
    .occ_o      (w_occ),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_data_o   (m_data),
    .m_last_o   (m_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_dpram_burst_reader.sv
// Scoreboard bench for dpram_burst_reader with a behavioural 1-cycle-latency RAM.
`default_nettype none

module tb_dpram_burst_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_addr;
  logic [8:0]  cmd_len;
  logic        busy;
  logic        done;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_dout;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;

  dpram_burst_reader dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .busy     (busy),
    .done     (done),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  logic [15:0] ram_mem [256];
  always @(posedge clk) if (ram_en) ram_dout <= ram_mem[ram_addr];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int          exp_addr_q [$];
  logic [16:0] exp_beat_q [$];
  int          outst    = 0;
  int          pops     = 0;
  int          done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    if (rst) begin
      outst      = 0;
      prev_stall = 1'b0;
    end else begin
      if (ram_en) begin
        check("ram_we", {31'b0, ram_we}, 0);
        if (exp_addr_q.size() == 0) check("unexpected_read", 1, 0);
        else check("ram_addr", {24'b0, ram_addr}, exp_addr_q.pop_front());
        outst++;
      end
      if (m_valid && prev_stall) begin
        check("hold_data", {16'b0, m_data}, {16'b0, prev_data});
        check("hold_last", {31'b0, m_last}, {31'b0, prev_last});
      end
      if (m_valid && m_ready) begin
        if (exp_beat_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          logic [16:0] e;
          e = exp_beat_q.pop_front();
          check("m_data", {16'b0, m_data}, {16'b0, e[15:0]});
          check("m_last", {31'b0, m_last}, {31'b0, e[16]});
        end
        if (m_last) check("done_with_last", {31'b0, done}, 1);
        outst--;
        pops++;
      end
      if (ram_en || (m_valid && m_ready)) check("outstanding_le2", (outst > 2) ? 1 : 0, 0);
      if (done) done_cnt++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic send_cmd(input int addr, input int len);
    int i;
    for (i = 0; i < 50 && !cmd_ready; i++) @(posedge clk);
    check("cmd_ready_wait", {31'b0, cmd_ready}, 1);
    for (int k = 0; k < len; k++) begin
      exp_addr_q.push_back((addr + k) % 256);
      exp_beat_q.push_back({(k == len - 1) ? 1'b1 : 1'b0, ram_mem[(addr + k) % 256]});
    end
    cmd_valid = 1'b1;
    cmd_addr  = addr[7:0];
    cmd_len   = len[8:0];
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (!busy && exp_beat_q.size() == 0 && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    #1 check("idle_timeout", {31'b0, ok}, 1);
  endtask

  initial begin
    int d0;
    int p0;
    logic [2:0] pat [6];
    pat = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1};
    for (int i = 0; i < 256; i++) ram_mem[i] = 16'(i * 3 + 100);
    ram_mem[0] = 16'd9;  ram_mem[1] = 16'd10; ram_mem[2] = 16'd7;
    ram_mem[3] = 16'd7;  ram_mem[4] = 16'd6;  ram_mem[5] = 16'd8;
    ram_mem[254] = 16'hAAAA; ram_mem[255] = 16'hBBBB;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_ram_en", {31'b0, ram_en}, 0);
    check("rst_ram_addr", {24'b0, ram_addr}, 0);
    check("rst_m_valid", {31'b0, m_valid}, 0);
    check("rst_m_data", {16'b0, m_data}, 0);
    check("rst_m_last", {31'b0, m_last}, 0);

    // Basic burst with latency and back-to-back output
    d0 = done_cnt;
    send_cmd(2, 4);
    @(negedge clk); check("lat_ram_en", {31'b0, ram_en}, 1);
    @(negedge clk); check("lat_no_valid_yet", {31'b0, m_valid}, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check("consecutive_valid", {31'b0, m_valid}, 1);
    end
    wait_idle();
    check("basic_done_count", done_cnt - d0, 1);
    check("basic_busy_clear", {31'b0, busy}, 0);

    // Address wrap
    d0 = done_cnt;
    send_cmd(254, 4);
    wait_idle();
    check("wrap_done_count", done_cnt - d0, 1);

    // Backpressure
    d0 = done_cnt;
    send_cmd(0, 6);
    for (int i = 0; i < 200; i++) begin
      m_ready = pat[i % 6][0];
      @(posedge clk);
      #1;
      if (!busy && exp_beat_q.size() == 0) break;
    end
    m_ready = 1'b1;
    wait_idle();
    check("bp_done_count", done_cnt - d0, 1);

    // Zero length
    d0 = done_cnt;
    send_cmd(3, 0);
    @(negedge clk);
    check("zlen_done", {31'b0, done}, 1);
    check("zlen_cmd_ready", {31'b0, cmd_ready}, 1);
    check("zlen_ram_en", {31'b0, ram_en}, 0);
    @(negedge clk);
    check("zlen_done_once", {31'b0, done}, 0);
    repeat (3) @(posedge clk);
    #1 check("zlen_done_count", done_cnt - d0, 1);

    // Command while busy is ignored
    d0 = done_cnt;
    send_cmd(2, 4);
    cmd_valid = 1'b1; cmd_addr = 8'd4; cmd_len = 9'd1;
    repeat (2) @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1 check("busy_cmd_done_count", done_cnt - d0, 1);
    check("busy_cmd_no_extra", exp_addr_q.size(), 0);

    // Reset mid-burst
    d0 = done_cnt;
    p0 = pops;
    send_cmd(0, 4);
    for (int i = 0; i < 50 && pops < p0 + 2; i++) @(negedge clk);
    check("mid_two_delivered", pops - p0, 2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_m_valid", {31'b0, m_valid}, 0);
    check("mid_rst_m_data", {16'b0, m_data}, 0);
    check("mid_rst_m_last", {31'b0, m_last}, 0);
    check("mid_rst_ram_en", {31'b0, ram_en}, 0);
    check("mid_rst_ram_addr", {24'b0, ram_addr}, 0);
    check("mid_rst_done", {31'b0, done}, 0);
    exp_addr_q.delete();
    exp_beat_q.delete();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("mid_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    send_cmd(0, 2);
    wait_idle();
    check("post_rst_done_count", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
